// File: rtl/uart_clk_pkg.sv
// Shared constants and helpers for the UART baud generator.
// Baud table assumes a 12 MHz hwclk and 16x oversampling.
package uart_clk_pkg;

  localparam int unsigned DEF_PERIOD_RST = 5;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  typedef enum logic [0:0] {
    BAUD_9600,
    BAUD_115200
  } baud_e;

  localparam logic [31:0] PERIOD_9600   = 32'd77;
  localparam logic [31:0] PERIOD_115200 = 32'd5;

  function automatic int ph_w(int os);
    return (os <= 2) ? 1 : $clog2(os);
  endfunction

  function automatic logic [31:0] baud_period(baud_e b);
    logic [31:0] p;
    p = PERIOD_115200;
    unique case (1'b1)
      (b == BAUD_9600):   p = PERIOD_9600;
      (b == BAUD_115200): p = PERIOD_115200;
      default:            p = PERIOD_115200;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control and strobe bundle between a UART and its baud generator.
// master drives the controls, slave is the generator.
interface uart_baud_gen_if #(
  parameter int CNT_W      = 32,
  parameter int OVERSAMPLE = 16
);

  localparam int PH_W = uart_clk_pkg::ph_w(OVERSAMPLE);

  logic             enable;
  logic             restart;
  logic [CNT_W-1:0] period;
  logic             period_we;
  logic             os_tick;
  logic             baud_tick;
  logic [PH_W-1:0]  phase;
  logic             clk_out;
  logic             load_pending;

  modport master (
    output enable,
    output restart,
    output period,
    output period_we,
    input  os_tick,
    input  baud_tick,
    input  phase,
    input  clk_out,
    input  load_pending
  );

  modport slave (
    input  enable,
    input  restart,
    input  period,
    input  period_we,
    output os_tick,
    output baud_tick,
    output phase,
    output clk_out,
    output load_pending
  );

endinterface

// File: rtl/uart_tick_div.sv
// Programmable divider: one-cycle tick every period_act+1 enabled
// cycles, with a shadow register so reloads land only on a wrap.
module uart_tick_div #(
  parameter int               CNT_W      = 32,
  parameter logic [CNT_W-1:0] PERIOD_RST = CNT_W'(5)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic [CNT_W-1:0] period,
  input  logic             period_we,
  output logic             tick,
  output logic             wrap,
  output logic             load_pending
);

  logic [CNT_W-1:0] cntr;
  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] period_shadow;

  assign wrap = enable && (cntr == period_act);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cntr          <= '0;
      tick          <= 1'b0;
      load_pending  <= 1'b0;
      period_act    <= PERIOD_RST;
      period_shadow <= PERIOD_RST;
    end else if (restart) begin
      cntr         <= '0;
      tick         <= 1'b0;
      load_pending <= 1'b0;
      if (period_we) begin
        period_act    <= period;
        period_shadow <= period;
      end else if (load_pending) begin
        period_act <= period_shadow;
      end
    end else begin
      tick <= wrap;
      if (wrap) begin
        cntr <= '0;
      end else if (enable) begin
        cntr <= cntr + CNT_W'(1);
      end
      // A write landing on the wrap itself bypasses the shadow stage.
      if (period_we) begin
        period_shadow <= period;
        if (wrap) begin
          period_act   <= period;
          load_pending <= 1'b0;
        end else begin
          load_pending <= 1'b1;
        end
      end else if (wrap && load_pending) begin
        period_act   <= period_shadow;
        load_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: oversample strobe, phase index, baud strobe
// and a registered square wave derived from one programmable divider.
module uart_baud_gen
  import uart_clk_pkg::*;
#(
  parameter int               CNT_W      = 32,
  parameter int               OVERSAMPLE = 16,
  parameter logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DEF_PERIOD_RST)
) (
  input  logic         hwclk,
  input  logic         reset,
  uart_baud_gen_if.slave bus
);

  localparam int PH_W = ph_w(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(OVERSAMPLE / 2);

  logic            wrap;
  logic            os_tick;
  logic            load_pending;
  logic            baud_tick;
  logic            clk_out;
  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] phase_nxt;

  uart_tick_div #(
    .CNT_W      (CNT_W),
    .PERIOD_RST (PERIOD_RST)
  ) u_os_div (
    .clk          (hwclk),
    .reset        (reset),
    .enable       (bus.enable),
    .restart      (bus.restart),
    .period       (bus.period),
    .period_we    (bus.period_we),
    .tick         (os_tick),
    .wrap         (wrap),
    .load_pending (load_pending)
  );

  assign phase_nxt = (phase == PH_LAST) ? '0 : phase + PH_W'(1);

  always_ff @(posedge hwclk) begin
    if (!reset) begin
      phase     <= '0;
      baud_tick <= 1'b0;
      clk_out   <= 1'b0;
    end else if (bus.restart) begin
      phase     <= '0;
      baud_tick <= 1'b0;
      clk_out   <= 1'b0;
    end else if (wrap) begin
      phase     <= phase_nxt;
      baud_tick <= (phase == PH_LAST);
      clk_out   <= (phase_nxt >= PH_HALF);
    end else begin
      baud_tick <= 1'b0;
    end
  end

  assign bus.os_tick      = os_tick;
  assign bus.baud_tick    = baud_tick;
  assign bus.phase        = phase;
  assign bus.clk_out      = clk_out;
  assign bus.load_pending = load_pending;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed and random checks of uart_baud_gen against an
// elapsed-cycle / tick-count reference model.
module tb_uart_baud_gen;

  localparam int CNT_W = 8;
  localparam int OS    = 4;
  localparam int PRST  = 3;

  logic hwclk = 1'b0;
  logic reset = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  uart_baud_gen_if #(.CNT_W(CNT_W), .OVERSAMPLE(OS)) bus ();

  uart_baud_gen #(
    .CNT_W      (CNT_W),
    .OVERSAMPLE (OS),
    .PERIOD_RST (CNT_W'(PRST))
  ) dut (
    .hwclk (hwclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 hwclk = ~hwclk;

  // reference: elapsed enabled cycles in the current period and
  // total os_ticks since reset/restart; outputs follow from those
  int m_since = 0;
  int m_act   = PRST;
  int m_shad  = PRST;
  bit m_pend  = 1'b0;
  int m_nt    = 0;
  bit m_os    = 1'b0;

  task automatic model();
    bit w;
    if (!reset) begin
      m_since = 0; m_act = PRST; m_shad = PRST;
      m_pend = 0; m_nt = 0; m_os = 0;
    end else if (bus.restart) begin
      m_since = 0; m_nt = 0; m_os = 0;
      if (bus.period_we) begin
        m_act = int'(bus.period); m_shad = int'(bus.period);
      end else if (m_pend) begin
        m_act = m_shad;
      end
      m_pend = 0;
    end else begin
      w = bus.enable && (m_since == m_act);
      m_os = w;
      if (w) begin
        m_since = 0; m_nt++;
      end else if (bus.enable) begin
        m_since++;
      end
      if (bus.period_we) begin
        m_shad = int'(bus.period);
        if (w) begin
          m_act = int'(bus.period); m_pend = 0;
        end else begin
          m_pend = 1;
        end
      end else if (w && m_pend) begin
        m_act = m_shad; m_pend = 0;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int ph;
    ph = m_nt % OS;
    chk("os_tick", 32'(bus.os_tick), 32'(m_os));
    chk("baud_tick", 32'(bus.baud_tick), 32'(m_os && ph == 0));
    chk("phase", 32'(bus.phase), 32'(ph));
    chk("clk_out", 32'(bus.clk_out), 32'(ph >= OS / 2));
    chk("load_pending", 32'(bus.load_pending), 32'(m_pend));
  endtask

  task automatic cyc();
    @(posedge hwclk);
    model();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.restart = 1'b0;
    bus.period_we = 1'b0;
    bus.period = '0;
    cyc();
    chk("rst_outs", {27'd0, bus.os_tick, bus.baud_tick, bus.clk_out,
        bus.load_pending, 1'b0}, 32'd0);
    chk("rst_phase", 32'(bus.phase), 32'd0);
    cyc();
    reset = 1'b1;
    bus.enable = 1'b1;
  endtask

  initial begin
    do_reset();

    // free run: ticks every 4 cycles, baud every 16
    for (int c = 1; c <= 32; c++) begin
      cyc();
      if (c % 4 == 0) begin
        chk("s1_tick", 32'(bus.os_tick), 32'd1);
        chk("s1_phase", 32'(bus.phase), 32'((c / 4) % OS));
      end
      if (c == 7) chk("s1_clk7", 32'(bus.clk_out), 32'd0);
      if (c == 8) chk("s1_clk8", 32'(bus.clk_out), 32'd1);
      if (c == 8) chk("s1_baud8", 32'(bus.baud_tick), 32'd0);
      if (c == 16) chk("s1_clk16", 32'(bus.clk_out), 32'd0);
      if (c == 16 || c == 32) chk("s1_baud", 32'(bus.baud_tick), 32'd1);
    end

    // shadowed reload mid-count
    do_reset();
    repeat (6) cyc();
    bus.period = 8'd1; bus.period_we = 1'b1;
    cyc();
    bus.period_we = 1'b0;
    chk("s2_pend7", 32'(bus.load_pending), 32'd1);
    cyc();
    chk("s2_tick8", 32'(bus.os_tick), 32'd1);
    chk("s2_pend8", 32'(bus.load_pending), 32'd0);
    cyc();
    chk("s2_tick9", 32'(bus.os_tick), 32'd0);
    cyc();
    chk("s2_tick10", 32'(bus.os_tick), 32'd1);
    repeat (4) cyc();

    // write landing on a wrap goes straight to the active period
    do_reset();
    repeat (7) cyc();
    bus.period = 8'd0; bus.period_we = 1'b1;
    cyc();
    bus.period_we = 1'b0;
    chk("s3_pend", 32'(bus.load_pending), 32'd0);
    chk("s3_tick8", 32'(bus.os_tick), 32'd1);
    cyc();
    chk("s3_tick9", 32'(bus.os_tick), 32'd1);
    cyc();
    chk("s3_tick10", 32'(bus.os_tick), 32'd1);
    repeat (6) cyc();

    // enable gap freezes everything
    do_reset();
    repeat (5) cyc();
    bus.enable = 1'b0;
    repeat (5) begin
      cyc();
      chk("s4_tick_off", 32'(bus.os_tick), 32'd0);
      chk("s4_phase_hold", 32'(bus.phase), 32'd1);
    end
    bus.enable = 1'b1;
    repeat (12) cyc();

    // restart applies a pending write
    do_reset();
    repeat (9) cyc();
    bus.period = 8'd7; bus.period_we = 1'b1;
    cyc();
    bus.period_we = 1'b0;
    bus.restart = 1'b1;
    cyc();
    bus.restart = 1'b0;
    chk("s5_phase", 32'(bus.phase), 32'd0);
    chk("s5_clk", 32'(bus.clk_out), 32'd0);
    chk("s5_pend", 32'(bus.load_pending), 32'd0);
    repeat (7) cyc();
    chk("s5_tick18", 32'(bus.os_tick), 32'd0);
    cyc();
    chk("s5_tick19", 32'(bus.os_tick), 32'd1);
    repeat (8) cyc();

    // reset mid-count with clk_out high
    do_reset();
    repeat (9) cyc();
    chk("s6_clk_hi", 32'(bus.clk_out), 32'd1);
    reset = 1'b0;
    cyc();
    chk("s6_outs", {28'd0, bus.os_tick, bus.baud_tick, bus.clk_out,
        bus.load_pending}, 32'd0);
    chk("s6_phase", 32'(bus.phase), 32'd0);
    reset = 1'b1;
    repeat (4) cyc();
    chk("s6_tick4", 32'(bus.os_tick), 32'd1);

    // full-scale period
    do_reset();
    bus.period = 8'd255; bus.period_we = 1'b1;
    cyc();
    bus.period_we = 1'b0;
    repeat (1100) cyc();

    // random enable / restart / reload traffic
    do_reset();
    repeat (3000) begin
      bus.enable    = ($urandom_range(0, 9) != 0);
      bus.restart   = ($urandom_range(0, 49) == 0);
      bus.period_we = ($urandom_range(0, 14) == 0);
      bus.period    = CNT_W'($urandom_range(0, 5));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
